fft_stage_sequencer: RTL and testbench

Iterative scheduler for the 16-point radix-2 DIT FFT. The core reuses one 8-butterfly array (input pairs 1..16, twiddles 1..8) for all four passes. It computes per-stage operand addresses and twiddle indices for the in-place sample buffer, paces each pass with a settle window, and pulses a capture strobe so the buffer writes butterfly results back in place. The sample buffer is preloaded externally in bit-reversed order before `start`.

---
 rtl/fft_stage_sequencer.sv | 99 +++++++++
 tb/tb_fft_stage_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: four-pass in-place scheduler for a 16-point radix-2 DIT FFT on one 8-butterfly array.
// Optional conjugate twiddles for the inverse transform when FFT_INVERSE_EN is defined.
module fft_stage_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        abort,
`ifdef FFT_INVERSE_EN
  input  logic        inverse,
`endif
  output logic        busy,
  output logic        done,
  output logic [1:0]  stage,
  output logic        capture,
  output logic [63:0] src_index,
  output logic [31:0] twiddle_index
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, FIN} state_t;
  state_t state_q, state_d;
  logic [1:0] stage_q, stage_d;
  logic [3:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, capture_q, capture_d;
  logic accept;
  assign accept = state_q == IDLE && start && !abort;
`ifdef FFT_INVERSE_EN
  logic inv_q, inv_d;
  assign inv_d = accept ? inverse : inv_q;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) inv_q <= 1'b0;
    else inv_q <= inv_d;
`else
  logic inv_q;
  assign inv_q = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:  state_d = accept ? ISSUE : IDLE;
      ISSUE: begin
        state_d = cnt_q == 4'(SETTLE_CYCLES - 1) ? CAPT : ISSUE;
        cnt_d   = cnt_q == 4'(SETTLE_CYCLES - 1) ? 4'd0 : cnt_q + 4'd1;
      end
      CAPT: begin
        state_d = stage_q == 2'd3 ? FIN : ISSUE;
        stage_d = stage_q == 2'd3 ? stage_q : stage_q + 2'd1;
      end
      FIN: begin
        state_d = IDLE;
        stage_d = 2'd0;
      end
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      stage_d = 2'd0;
      cnt_d   = 4'd0;
    end
    busy_d    = state_d != IDLE;
    capture_d = state_d == CAPT;
    done_d    = state_d == FIN;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q   <= IDLE;
      stage_q   <= 2'd0;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      capture_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      capture_q <= capture_d;
    end
  // butterfly k pairs top/top+span; the inverse twiddle is the 4-bit negation of the exponent
  always_comb begin
    src_index     = '0;
    twiddle_index = '0;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] pos, top, e;
      pos = 4'(k) & ((4'd1 << stage_q) - 4'd1);
      top = ((4'(k) >> stage_q) << (3'(stage_q) + 3'd1)) + pos;
      e   = pos << (2'd3 - stage_q);
      src_index[8*k +: 4]     = top;
      src_index[8*k+4 +: 4]   = top + (4'd1 << stage_q);
      twiddle_index[4*k +: 4] = inv_q ? 4'd0 - e : e;
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign capture = capture_q;
  assign stage   = stage_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: scoreboard bench driving an S=1 and an S=3 sequencer cycle by cycle.
module tb_fft_stage_sequencer;
  logic clk = 1'b0, n_rst, start1, start3, abort, inverse;
  logic busy1, done1, cap1, busy3, done3, cap3;
  logic [1:0] stage1, stage3;
  logic [63:0] src1, src3;
  logic [31:0] tw1, tw3;
  int total = 0, bad = 0;
  typedef struct {
    int c;
    logic busy, capture, done;
    logic [1:0] stage;
    logic [63:0] src;
    logic [31:0] tw;
    bit inv;
  } exp_t;
  exp_t q1[$], q3[$];
  always #5 clk = ~clk;
  fft_stage_sequencer #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .n_rst(n_rst), .start(start1), .abort(abort),
`ifdef FFT_INVERSE_EN
    .inverse(inverse),
`endif
    .busy(busy1), .done(done1), .stage(stage1), .capture(cap1),
    .src_index(src1), .twiddle_index(tw1));
  fft_stage_sequencer #(.SETTLE_CYCLES(3)) u3 (
    .clk(clk), .n_rst(n_rst), .start(start3), .abort(abort),
`ifdef FFT_INVERSE_EN
    .inverse(inverse),
`endif
    .busy(busy3), .done(done3), .stage(stage3), .capture(cap3),
    .src_index(src3), .twiddle_index(tw3));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  // expected outputs in cycle c after a start sampled at the edge ending cycle 0
  function automatic exp_t model(input int s, input int c, input bit inv);
    exp_t e;
    int p, last, k, span, t;
    p = s + 1;
    last = 4 * p + 1;
    e.c = c; e.busy = 0; e.capture = 0; e.done = 0; e.stage = 0; e.inv = inv;
    if (c >= 1 && c <= last) begin
      e.busy = 1;
      e.done = c == last;
      e.stage = c == last ? 2'd3 : 2'((c - 1) / p);
      e.capture = c < last && (c - 1) % p == s;
    end
    span = 1 << e.stage;
    k = 0;
    e.src = '0;
    e.tw = '0;
    for (int i = 0; i < 16; i++)
      if (((i >> e.stage) & 1) == 0) begin
        t = (i % span) * (8 >> e.stage);
        if (inv) t = (16 - t) % 16;
        e.src[8*k +: 4] = 4'(i);
        e.src[8*k+4 +: 4] = 4'(i + span);
        e.tw[4*k +: 4] = 4'(t);
        k++;
      end
    return e;
  endfunction
  task automatic check_obs(input int u, input exp_t e, input logic b, input logic cp, input logic d,
                           input logic [1:0] st, input logic [63:0] src, input logic [31:0] tw);
    chk($sformatf("u%0d c%0d ctl", u, e.c), {b, cp, d, st}, {e.busy, e.capture, e.done, e.stage});
    chk($sformatf("u%0d c%0d src", u, e.c), src, e.src);
    chk($sformatf("u%0d c%0d tw", u, e.c), tw, e.tw);
    if (e.busy && !e.inv && e.stage == 2'd1)
      chk("s1b3", {src[27:24], src[31:28], tw[15:12]}, {4'd5, 4'd7, 4'd4});
    if (e.busy && !e.inv && e.stage == 2'd2)
      chk("s2b5", {src[43:40], src[47:44], tw[23:20]}, {4'd9, 4'd13, 4'd2});
    if (e.busy && !e.inv && e.stage == 2'd3)
      chk("s3b7", {src[59:56], src[63:60], tw[31:28]}, {4'd7, 4'd15, 4'd7});
    if (e.busy && e.inv && e.stage == 2'd3) chk("inv s3b7", tw[31:28], 4'd9);
    if (e.busy && e.inv && e.stage == 2'd2) chk("inv s2b5", tw[23:20], 4'd14);
    if (e.busy && e.inv) chk("inv b0", tw[3:0], 4'd0);
  endtask
  always @(negedge clk) begin
    if (q1.size() > 0) check_obs(1, q1.pop_front(), busy1, cap1, done1, stage1, src1, tw1);
    if (q3.size() > 0) check_obs(3, q3.pop_front(), busy3, cap3, done3, stage3, src3, tw3);
  end
  task automatic rst_chk(input string tag);
    chk({tag, " u1 ctl"}, {busy1, done1, cap1, stage1}, 5'd0);
    chk({tag, " u1 src"}, src1, 64'hFEDCBA9876543210);
    chk({tag, " u1 tw"}, tw1, 32'd0);
    chk({tag, " u3 ctl"}, {busy3, done3, cap3, stage3}, 5'd0);
    chk({tag, " u3 src"}, src3, 64'hFEDCBA9876543210);
    chk({tag, " u3 tw"}, tw3, 32'd0);
  endtask
  task automatic drv(input int s, input bit st, input bit ab);
    start1 = s == 1 && st;
    start3 = s == 3 && st;
    abort = ab;
  endtask
  task automatic idle(input int n, input bit sa);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      q1.push_back(model(1, 0, 0));
      q3.push_back(model(3, 0, 0));
      start1 = sa; start3 = sa; abort = sa;
    end
  endtask
  // ab: cycle carrying abort; rc: cycle in which n_rst is pulsed (-1 for none)
  task automatic launch(input int s, input bit inv, input int ab, input int rc);
    int last, stop;
    last = 4 * (s + 1) + 1;
    stop = ab >= 0 ? ab : (rc >= 0 ? rc - 1 : last);
    @(posedge clk); #1;
    for (int c = 0; c <= stop; c++)
      if (s == 1) q1.push_back(model(s, c, inv));
      else q3.push_back(model(s, c, inv));
    drv(s, 1, 0);
    inverse = inv;
    for (int c = 1; c <= (rc >= 0 ? rc : stop); c++) begin
      @(posedge clk); #1;
      drv(s, c == 3 || c == last, c == ab);
      inverse = ~inv;
      if (c == rc) begin
        n_rst = 1'b0;
        #1 rst_chk("midrst");
        #2 n_rst = 1'b1;
      end
    end
  endtask
  initial begin
    n_rst = 1'b0; start1 = 0; start3 = 0; abort = 0; inverse = 0;
    #2 rst_chk("reset");
    #1 n_rst = 1'b1;
    idle(2, 0);
    launch(1, 0, -1, -1);
    launch(1, 0, -1, -1);
    idle(2, 0);
    idle(1, 1);
    idle(2, 0);
    launch(1, 0, 5, -1);
    idle(3, 0);
    launch(3, 0, -1, -1);
    idle(2, 0);
    launch(3, 0, -1, 10);
    idle(3, 0);
`ifdef FFT_INVERSE_EN
    launch(1, 1, -1, -1);
    idle(2, 0);
    launch(1, 0, -1, -1);
    idle(2, 0);
`endif
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
